// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: buffers scan-code bytes in an 8-entry FIFO and
// drives each one out as an 11-bit PS/2 frame on self-generated clock and data.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | lines high, waiting for a queued byte with the host not inhibiting
// HI    | ps2_clk high, current frame bit on ps2_data
// LO    | ps2_clk low, host samples the bit held since HI
// GAP   | lines high for GAP_HALVES half-periods after a frame or an abort
module ps2_dev_tx #(
   parameter int CLK_DIV    = 8,
   parameter int GAP_HALVES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       host_inhibit,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic [3:0] fifo_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_HALVES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] mem [8];
   logic [2:0] wr_ptr;
   logic [2:0] rd_ptr;
   logic [3:0] count;
   logic       inh_meta;
   logic       inh;
   logic [7:0] div;
   logic [7:0] div_nxt;
   logic [7:0] half;
   logic [7:0] half_nxt;
   logic [3:0] idx;
   logic [3:0] idx_nxt;
   logic       clk_nxt;
   logic       data_nxt;
   logic       push;
   logic       pop;
   logic       half_end;
   logic       abort_ok;
   logic [7:0] head;

   // Bit i of the frame: start, eight data bits LSB first, odd parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] i);
      logic b;
      if (i == 4'd0) begin
         b = 1'b0;
      end else if (i <= 4'd8) begin
         b = d[3'(i - 4'd1)];
      end else if (i == 4'd9) begin
         b = ~^d;
      end else begin
         b = 1'b1;
      end
      return b;
   endfunction

   assign in_ready   = (count != 4'd8);
   assign push       = in_valid && in_ready;
   assign busy       = (state != IDLE);
   assign fifo_count = count;
   assign head       = mem[rd_ptr];
   assign half_end   = (div == DIV_LAST);
   // Once the stop bit is on the wire the byte counts as delivered.
   assign abort_ok   = inh && (idx <= 4'd9);

   always_comb begin
      state_nxt = state;
      div_nxt   = half_end ? 8'd0 : div + 8'd1;
      half_nxt  = half;
      idx_nxt   = idx;
      clk_nxt   = ps2_clk;
      data_nxt  = ps2_data;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            div_nxt  = 8'd0;
            half_nxt = 8'd0;
            clk_nxt  = 1'b1;
            data_nxt = 1'b1;
            if (count != 4'd0 && !inh) begin
               state_nxt = HI;
               idx_nxt   = 4'd0;
               data_nxt  = frame_bit(head, 4'd0);
            end
         end
         HI: begin
            clk_nxt = 1'b1;
            if (abort_ok) begin
               state_nxt = GAP;
               div_nxt   = 8'd0;
               half_nxt  = 8'd0;
               data_nxt  = 1'b1;
            end else if (half_end) begin
               state_nxt = LO;
               clk_nxt   = 1'b0;
            end
         end
         LO: begin
            if (abort_ok) begin
               state_nxt = GAP;
               div_nxt   = 8'd0;
               half_nxt  = 8'd0;
               clk_nxt   = 1'b1;
               data_nxt  = 1'b1;
            end else if (half_end) begin
               clk_nxt = 1'b1;
               if (idx < 4'd10) begin
                  state_nxt = HI;
                  idx_nxt   = idx + 4'd1;
                  data_nxt  = frame_bit(head, idx + 4'd1);
               end else begin
                  state_nxt = GAP;
                  half_nxt  = 8'd0;
                  data_nxt  = 1'b1;
                  pop       = 1'b1;
               end
            end
         end
         GAP: begin
            clk_nxt  = 1'b1;
            data_nxt = 1'b1;
            if (half_end) begin
               if (half == GAP_LAST) begin
                  state_nxt = IDLE;
               end else begin
                  half_nxt = half + 8'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            div_nxt   = 8'd0;
            clk_nxt   = 1'b1;
            data_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         div      <= 8'd0;
         half     <= 8'd0;
         idx      <= 4'd0;
         ps2_clk  <= 1'b1;
         ps2_data <= 1'b1;
         inh_meta <= 1'b0;
         inh      <= 1'b0;
      end else begin
         state    <= state_nxt;
         div      <= div_nxt;
         half     <= half_nxt;
         idx      <= idx_nxt;
         ps2_clk  <= clk_nxt;
         ps2_data <= data_nxt;
         inh_meta <= host_inhibit;
         inh      <= inh_meta;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         count  <= 4'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 3'd1;
         if (pop)  rd_ptr <= rd_ptr + 3'd1;
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone decide what is valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx: decodes frames at ps2_clk falls and checks
// framing, timing, FIFO behaviour, host inhibit and mid-frame reset.
module tb_ps2_dev_tx;
   localparam int CLK_DIV    = 4;
   localparam int GAP_HALVES = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       host_inhibit = 1'b0;
   logic       in_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic [3:0] fifo_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   ps2_dev_tx #(.CLK_DIV(CLK_DIV), .GAP_HALVES(GAP_HALVES)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .host_inhibit(host_inhibit),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .busy(busy),
      .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] make_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_falls(input int k);
      int   n = 0;
      int   falls = 0;
      logic prev = ps2_clk;
      while (falls < k && n < 1000) begin
         @(negedge clock);
         n++;
         if (prev && !ps2_clk) falls++;
         prev = ps2_clk;
      end
      chk("falls_timeout", falls, k);
   endtask

   // Collect one frame; optionally raise host_inhibit on the rise after fall inh_at.
   task automatic recv_frame(input int inh_at, output logic [10:0] bits,
                             output int t_fall0, output int t_end);
      int   n = 0;
      int   falls = 0;
      logic done = 1'b0;
      logic prev = ps2_clk;
      bits    = '0;
      t_fall0 = 0;
      t_end   = 0;
      while (!done && n < 2000) begin
         @(negedge clock);
         n++;
         if (prev && !ps2_clk) begin
            if (falls == 0) t_fall0 = cyc;
            if (falls < 11) bits[falls] = ps2_data;
            falls++;
         end else if (!prev && ps2_clk) begin
            if (falls == 11) begin
               t_end = cyc;
               done  = 1'b1;
            end else if (falls == inh_at) begin
               host_inhibit = 1'b1;
            end
         end
         prev = ps2_clk;
      end
      chk("recv_timeout", {31'd0, done}, 32'd1);
   endtask

   logic [10:0] fr;
   int          t0;
   int          te;
   int          te_prev;
   int          c1;
   int          n;
   logic [7:0]  exp_b;

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_clk", {31'd0, ps2_clk}, 32'd1);
      chk("rst_data", {31'd0, ps2_data}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {28'd0, fifo_count}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;
      @(negedge clock);

      // single byte 0x1C: latency, bit sequence, frame length, gap length
      push(8'h1C);
      chk("lat_busy_e0", {31'd0, busy}, 32'd0);
      chk("lat_count_e0", {28'd0, fifo_count}, 32'd1);
      @(negedge clock);
      c1 = cyc;
      chk("lat_busy_e1", {31'd0, busy}, 32'd1);
      chk("lat_data_e1", {31'd0, ps2_data}, 32'd0);
      chk("lat_clk_e1", {31'd0, ps2_clk}, 32'd1);
      recv_frame(-1, fr, t0, te);
      chk("f1c_bits", {21'd0, fr}, 32'h438);
      chk("f1c_first_fall", t0 - c1, 4);
      chk("f1c_frame_len", te - c1, 88);
      chk("f1c_count_end", {28'd0, fifo_count}, 32'd0);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("f1c_gap_len", n, 16);

      // parity: 0xF0 and 0x00 back to back
      push(8'hF0);
      push(8'h00);
      recv_frame(-1, fr, t0, te);
      chk("pf0_bits", {21'd0, fr}, 32'h7E0);
      chk("pf0_len", te - t0, 84);
      te_prev = te;
      recv_frame(-1, fr, t0, te);
      chk("p00_bits", {21'd0, fr}, 32'h600);
      chk("p00_b2b_gap", t0 - te_prev, 21);
      wait_idle();

      // FIFO full while held idle by inhibit, then wrap
      host_inhibit = 1'b1;
      repeat (3) @(negedge clock);
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + i);
         @(negedge clock);
         if (i == 7) begin
            chk("full_ready", {31'd0, in_ready}, 32'd0);
            chk("full_count", {28'd0, fifo_count}, 32'd8);
         end
      end
      in_valid = 1'b0;
      chk("full_ninth_ignored", {28'd0, fifo_count}, 32'd8);
      chk("full_inh_idle", {31'd0, busy}, 32'd0);
      host_inhibit = 1'b0;
      for (int k = 0; k < 4; k++) begin
         recv_frame(-1, fr, t0, te);
         chk("full_frame_a", {21'd0, fr}, {21'd0, make_frame(8'(8'h10 + k))});
      end
      chk("full_count4", {28'd0, fifo_count}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'hA0 + i);
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk("wrap_count", {28'd0, fifo_count}, 32'd8);
      chk("wrap_ready", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         exp_b = (k < 4) ? 8'(8'h14 + k) : 8'(8'hA0 + k - 4);
         recv_frame(-1, fr, t0, te);
         chk("wrap_frame", {21'd0, fr}, {21'd0, make_frame(exp_b)});
      end
      chk("wrap_count_end", {28'd0, fifo_count}, 32'd0);
      wait_idle();

      // inhibit during bit 5 of 0x5A: abort, hold, resend whole
      push(8'h5A);
      wait_falls(6);
      host_inhibit = 1'b1;
      repeat (3) @(negedge clock);
      chk("abort_clk", {31'd0, ps2_clk}, 32'd1);
      chk("abort_data", {31'd0, ps2_data}, 32'd1);
      chk("abort_count", {28'd0, fifo_count}, 32'd1);
      repeat (40) @(negedge clock);
      chk("abort_hold_idle", {31'd0, busy}, 32'd0);
      chk("abort_hold_count", {28'd0, fifo_count}, 32'd1);
      host_inhibit = 1'b0;
      recv_frame(-1, fr, t0, te);
      chk("resend_bits", {21'd0, fr}, 32'h6B4);
      chk("resend_len", te - t0, 84);
      chk("resend_count", {28'd0, fifo_count}, 32'd0);
      wait_idle();

      // inhibit raised during the stop bit: frame completes, byte popped
      push(8'h33);
      recv_frame(10, fr, t0, te);
      chk("stop_inh_bits", {21'd0, fr}, {21'd0, make_frame(8'h33)});
      chk("stop_inh_len", te - t0, 84);
      chk("stop_inh_count", {28'd0, fifo_count}, 32'd0);
      wait_idle();
      host_inhibit = 1'b0;
      repeat (3) @(negedge clock);

      // reset at bit 3 with three bytes queued
      push(8'h01);
      push(8'h02);
      push(8'h03);
      wait_falls(4);
      reset_n = 1'b0;
      @(negedge clock);
      chk("mrst_clk", {31'd0, ps2_clk}, 32'd1);
      chk("mrst_data", {31'd0, ps2_data}, 32'd1);
      chk("mrst_count", {28'd0, fifo_count}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      chk("mrst_stay_idle", {31'd0, busy}, 32'd0);

      // receiver-style decode of 0xE0, 0x75
      push(8'hE0);
      push(8'h75);
      recv_frame(-1, fr, t0, te);
      chk("lb_frame0", {21'd0, fr}, 32'h5C0);
      chk("lb_byte0", {24'd0, fr[8:1]}, 32'hE0);
      recv_frame(-1, fr, t0, te);
      chk("lb_frame1", {21'd0, fr}, 32'h4EA);
      chk("lb_byte1", {24'd0, fr[8:1]}, 32'h75);
      chk("lb_count", {28'd0, fifo_count}, 32'd0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ps2_dev_tx.md
Name: ps2_dev_tx

Overview:
Device-side PS/2 transmitter. It is the keyboard end of the PS/2 link that the SoC's APB PS/2 receiver listens to. Scan-code bytes are pushed into an 8-entry FIFO through a valid/ready port. The block serialises each byte into a standard 11-bit PS/2 frame, generating both ps2_clk and ps2_data itself. It serves as the keyboard model in SoC simulation and can be looped directly into the receiver's ps2_clk/ps2_data inputs.

Parameters:
CLK_DIV, 8, system clocks per PS/2 half-period; legal range 2..255.
GAP_HALVES, 4, idle half-periods inserted after every frame or abort; legal range 1..255.

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset_n  input  1  synchronous, active-low reset
in_valid  input  1  byte push request
in_data  input  8  scan-code byte to push
in_ready  output  1  FIFO can accept; equals (fifo_count != 8)
host_inhibit  input  1  asynchronous; high means the host is holding the clock low (inhibit)
ps2_clk  output  1  PS/2 clock; idle high; registered
ps2_data  output  1  PS/2 data; idle high; registered
busy  output  1  high in any state other than IDLE
fifo_count  output  4  number of bytes held, 0..8

Behaviour:
- Reset: reset is synchronous on reset_n (active-low), clock is clock. On reset: ps2_clk=1, ps2_data=1, busy=0, fifo_count=0, in_ready=1, pointers=0, state=IDLE, divider=0, bit index=0, inhibit synchroniser cleared to 0.
- Reset mid-frame: outputs return high on the next edge, and all FIFO contents are discarded.
- FIFO:
  - 8 entries; 3-bit read and write pointers wrap modulo 8.
  - Push occurs when in_valid && in_ready. Pop occurs only on successful completion of a frame.
  - Push and pop in the same cycle: count is unchanged.
  - When full, in_ready=0 even if a pop happens that cycle, so the push is ignored.
- Inhibit: host_inhibit passes through a 2-flop synchroniser; inh denotes the synchronised value.
- Frame format: bit index 0..10 = start(0), d[0]..d[7] (LSB first), odd parity (~^d), stop(1).
- Half-period counter: counts 0..CLK_DIV-1. A half ends on the cycle the counter equals CLK_DIV-1; the counter reloads to 0 at each state change.
- FSM states:
  - IDLE: ps2_clk=1, ps2_data=1. If fifo_count != 0 && !inh, move to HI on the next edge with bit index=0. On that same edge ps2_data takes frame bit 0; ps2_clk stays 1. The byte is read from the FIFO head without popping.
  - HI: ps2_clk=1, ps2_data=current bit, held for CLK_DIV cycles. At the end of the half, move to LO and set ps2_clk=0 (falling edge; data has been stable for CLK_DIV cycles).
  - LO: ps2_clk=0, held for CLK_DIV cycles. At the end of the half:
    - If bit index < 10: increment the index, go to HI, ps2_clk=1, ps2_data=next bit.
    - If bit index == 10: pop the FIFO, go to GAP, ps2_clk=1, ps2_data=1.
  - GAP: ps2_clk=1, ps2_data=1, held for GAP_HALVES*CLK_DIV cycles, then IDLE.
- Frame timing: exactly 22*CLK_DIV cycles from entry to HI (bit 0) until entry to GAP.
- Abort:
  - If inh=1 in HI or LO while bit index <= 9: go to GAP on the next edge, drive ps2_clk=1 and ps2_data=1, do not pop. The same byte is retransmitted from bit 0 after GAP, once inh is low.
  - If inh=1 during bit 10 (stop bit): no abort; the frame completes and the byte is popped.
- Latency: a push accepted at edge E0 while IDLE and empty gives busy=1 and ps2_data=0 from edge E1. The first ps2_clk fall occurs at E1+CLK_DIV.
- Back-to-back bytes: the next frame starts on the edge after GAP ends, provided the FIFO is non-empty.
- A write into the FIFO entry currently being sent is impossible: such a write can only happen when the FIFO is full, and in_ready is low then.

Test Plan:
- Single byte, CLK_DIV=4: push 0x1C. ps2_data sampled at each ps2_clk fall must read 0,0,0,1,1,1,0,0,0,0,1. Frame is 88 cycles; fifo_count goes 1→0 at frame end; busy drops after 16 GAP cycles.
- Parity: push 0xF0 then 0x00. Parity bits must be 1 and 1; stop bit is 1 in both frames.
- Loopback with the SoC APB PS/2 receiver: push 0xE0, 0x75. APB reads must return 0xE0 then 0x75, with no frames dropped.
- FIFO full: push 9 bytes back-to-back while IDLE. in_ready must be 0 after the 8th push, the 9th is ignored, fifo_count=8. All 8 bytes are emitted in order; pointer wrap is checked by pushing 4 more after 4 frames.
- Inhibit: assert host_inhibit during bit 5 of byte 0x5A. Lines return high within 3 cycles, fifo_count is unchanged. After release, 0x5A is resent whole. Inhibit during the stop bit: the frame completes and the byte is popped.
- Reset mid-frame at bit 3 with 3 bytes queued: the next cycle shows ps2_clk=1, ps2_data=1, fifo_count=0, busy=0, in_ready=1.
